// File: rtl/concat_packer.sv
// Sequential bit-field concatenator: appends replicated variable-width fields MSB-first
// and emits fixed OUT_W words through a single output slot, padding flushed partial words.
module concat_packer #(
    parameter int   IN_W    = 8,
    parameter int   OUT_W   = 32,
    parameter int   REP_W   = 4,
    parameter logic PAD_BIT = 1'b0,
    localparam int  LEN_W   = $clog2(IN_W + 1),
    localparam int  CNT_W   = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic [REP_W-1:0] in_rep,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_fill,
    output logic             out_last
);

    localparam int WIDE_W = OUT_W + IN_W;
    localparam int SUM_W  = $clog2(WIDE_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REP,
        S_FLUSH
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [OUT_W-1:0] r_acc,    w_acc_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [IN_W-1:0]  r_data,   w_data_nxt;
    logic [LEN_W-1:0] r_len,    w_len_nxt;
    logic             r_last,   w_last_nxt;
    logic [REP_W-1:0] r_remain, w_remain_nxt;
    logic             r_active;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_fill;
    logic             r_out_last;

    logic             w_load;
    logic [OUT_W-1:0] w_load_data;
    logic [CNT_W-1:0] w_load_fill;
    logic             w_load_last;
    logic             w_in_ready;
    logic             w_slot_free;

    // Append datapath, shared by the first copy (IDLE) and the repeats (REP).
    logic [LEN_W-1:0]  w_len_clamp;
    logic [IN_W-1:0]   w_app_data;
    logic [LEN_W-1:0]  w_app_len;
    logic [IN_W-1:0]   w_field;
    logic [WIDE_W-1:0] w_wide;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_over;
    logic              w_complete;
    logic              w_stall;
    logic [OUT_W-1:0]  w_word;
    logic [OUT_W-1:0]  w_app_acc;
    logic [CNT_W-1:0]  w_app_cnt;

    logic [CNT_W-1:0]  w_flush_sh;
    logic [OUT_W-1:0]  w_flush_word;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_len_clamp = (in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_len;

    assign w_app_data  = (r_state == S_REP) ? r_data : in_data;
    assign w_app_len   = (r_state == S_REP) ? r_len  : w_len_clamp;
    assign w_field     = w_app_data & ~({IN_W{1'b1}} << w_app_len);

    // acc is right-aligned: its low r_cnt bits are live, everything above is zero.
    assign w_wide      = ({{IN_W{1'b0}}, r_acc} << w_app_len) | {{OUT_W{1'b0}}, w_field};
    assign w_sum       = SUM_W'(r_cnt) + SUM_W'(w_app_len);
    assign w_complete  = (w_sum >= SUM_W'(OUT_W));
    assign w_over      = w_sum - SUM_W'(OUT_W);
    assign w_stall     = w_complete && !w_slot_free;

    assign w_word      = OUT_W'(w_wide >> w_over);
    assign w_app_acc   = w_complete ? OUT_W'(w_wide & ~({WIDE_W{1'b1}} << w_over))
                                    : OUT_W'(w_wide);
    assign w_app_cnt   = w_complete ? CNT_W'(w_over) : CNT_W'(w_sum);

    assign w_flush_sh   = CNT_W'(OUT_W) - r_cnt;
    assign w_flush_word = (r_acc << w_flush_sh)
                        | (PAD_BIT ? ~({OUT_W{1'b1}} << w_flush_sh) : {OUT_W{1'b0}});

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_len_nxt    = r_len;
        w_last_nxt   = r_last;
        w_remain_nxt = r_remain;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_load_data  = w_word;
        w_load_fill  = CNT_W'(OUT_W);
        w_load_last  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = r_active && !w_stall;
                if (in_valid && w_in_ready) begin
                    w_data_nxt = in_data;
                    w_len_nxt  = w_len_clamp;
                    w_last_nxt = in_last;
                    w_acc_nxt  = w_app_acc;
                    w_cnt_nxt  = w_app_cnt;
                    if (w_complete) begin
                        w_load      = 1'b1;
                        w_load_last = in_last && (in_rep <= REP_W'(1)) && (w_over == '0);
                    end
                    if (in_rep > REP_W'(1)) begin
                        w_remain_nxt = in_rep - REP_W'(1);
                        w_state_nxt  = S_REP;
                    end else if (in_last && (w_app_cnt != '0)) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end

            S_REP: begin
                if (!w_stall) begin
                    w_acc_nxt    = w_app_acc;
                    w_cnt_nxt    = w_app_cnt;
                    w_remain_nxt = r_remain - REP_W'(1);
                    if (w_complete) begin
                        w_load      = 1'b1;
                        w_load_last = r_last && (r_remain == REP_W'(1)) && (w_over == '0);
                    end
                    if (r_remain == REP_W'(1)) begin
                        w_state_nxt = (r_last && (w_app_cnt != '0)) ? S_FLUSH : S_IDLE;
                    end
                end
            end

            S_FLUSH: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_flush_word;
                    w_load_fill = r_cnt;
                    w_load_last = 1'b1;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_len       <= '0;
            r_last      <= 1'b0;
            r_remain    <= '0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_fill  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_len    <= w_len_nxt;
            r_last   <= w_last_nxt;
            r_remain <= w_remain_nxt;
            // A reload wins over a drain so the slot can turn over every cycle.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
                r_out_fill  <= w_load_fill;
                r_out_last  <= w_load_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_fill  = r_out_fill;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_concat_packer.sv
// Scoreboard bench for concat_packer (IN_W=8, OUT_W=16): a bit-queue model predicts words at
// field acceptance; a monitor compares delivered words and checks stall stability.
module tb_concat_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready_b;
    logic [7:0]  in_data;
    logic [3:0]  in_len;
    logic [3:0]  in_rep;
    logic        in_last;
    logic        out_valid, out_valid_b;
    logic        out_ready;
    logic [15:0] out_data, out_data_b;
    logic [4:0]  out_fill, out_fill_b;
    logic        out_last, out_last_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] data;
        int          fill;
        bit          last;
    } exp_t;

    exp_t sb[$];
    bit   mbits[$];
    bit   rnd_run;

    concat_packer #(.IN_W(8), .OUT_W(16), .REP_W(4), .PAD_BIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_rep(in_rep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fill(out_fill), .out_last(out_last)
    );

    concat_packer #(.IN_W(8), .OUT_W(16), .REP_W(4), .PAD_BIT(1'b1)) dut_pad1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_len(in_len), .in_rep(in_rep), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_fill(out_fill_b), .out_last(out_last_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: serialise every copy bit by bit, cut 16-bit words, flush on last.
    task automatic model_field(input int len, input logic [7:0] data, input int rep, input bit last);
        int   l = (len > 8) ? 8 : len;
        int   r = (rep == 0) ? 1 : rep;
        exp_t e;
        for (int c = 0; c < r; c++) begin
            for (int b = l - 1; b >= 0; b--) begin
                mbits.push_back(data[b]);
                if (mbits.size() == 16) begin
                    e.data = '0;
                    for (int k = 0; k < 16; k++) e.data[15-k] = mbits.pop_front();
                    e.fill = 16;
                    e.last = last && (c == r - 1) && (b == 0);
                    sb.push_back(e);
                end
            end
        end
        if (last && mbits.size() > 0) begin
            e.data = '0;
            e.fill = mbits.size();
            for (int k = 0; k < e.fill; k++) e.data[15-k] = mbits.pop_front();
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic send_field(input int len, input logic [7:0] data, input int rep,
                              input bit last, output int waited);
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_len   = 4'(len);
        in_data  = data;
        in_rep   = 4'(rep);
        in_last  = last;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        model_field(len, data, rep, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int len, input logic [7:0] data, input int rep, input bit last);
        int w;
        send_field(len, data, rep, last, w);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Monitor: pop and compare on every handshake; a stalled word must not change.
    logic [15:0] held_data;
    logic [4:0]  held_fill;
    logic        held_last;
    bit          hold = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] pad;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {16'd0, out_data}, {16'd0, held_data});
                check("hold_fill", {27'd0, out_fill}, {27'd0, held_fill});
                check("hold_last", {31'd0, out_last}, {31'd0, held_last});
            end
            if (out_valid && out_ready) begin
                hold = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e   = sb.pop_front();
                    pad = (e.fill >= 16) ? 16'h0000 : (16'hFFFF >> e.fill);
                    check("word_data", {16'd0, out_data}, {16'd0, e.data});
                    check("word_fill", {27'd0, out_fill}, 32'(e.fill));
                    check("word_last", {31'd0, out_last}, {31'd0, e.last});
                    check("pad1_valid", {31'd0, out_valid_b}, 32'd1);
                    check("pad1_data", {16'd0, out_data_b}, {16'd0, e.data | pad});
                end
            end else if (out_valid) begin
                hold      = 1'b1;
                held_data = out_data;
                held_fill = out_fill;
                held_last = out_last;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  {16'd0, out_data},  32'd0);
        check({tag, "_out_fill"},  {27'd0, out_fill},  32'd0);
        check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_rep    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic two-field word
        send(8, 8'hA5, 1, 1'b0);
        send(8, 8'h3C, 1, 1'b1);
        wait_drain("basic");

        // Replication: three REP cycles, exact fill, no flush word
        send(4, 8'h09, 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rep_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        check("rep_in_ready_back", {31'd0, in_ready}, 32'd1);
        wait_drain("rep");

        // Partial flush (pad 0 and pad 1 instances)
        send(3, 8'h05, 1, 1'b1);
        wait_drain("flush");

        // Straddle across a word boundary
        send(6, 8'h3F, 1, 1'b0);
        send(6, 8'h00, 1, 1'b0);
        send(6, 8'h2A, 1, 1'b1);
        wait_drain("straddle");

        // Straddle under backpressure until cycle 10
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                send(6, 8'h3F, 1, 1'b0);
                send(6, 8'h00, 1, 1'b0);
                send(6, 8'h2A, 1, 1'b1);
                @(negedge clk);
                #1;
                check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("bp_straddle");

        // A word-completing field must wait while the slot is occupied
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                send(8, 8'hA5, 1, 1'b0);
                send(8, 8'h3C, 1, 1'b0);
                send(8, 8'h11, 1, 1'b0);
                send_field(8, 8'h22, 1, 1'b1, w);
                check("bp_stalled", {31'd0, (w > 0)}, 32'd1);
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("bp_slot");

        // Reset in the middle of a replication burst discards everything
        send(2, 8'h02, 7, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rep_reset");
        mbits.delete();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8, 8'hA5, 1, 1'b0);
        send(8, 8'h3C, 1, 1'b1);
        wait_drain("after_reset");

        // Randomised frames: zero lengths, clamped lengths, rep 0, random backpressure
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send($urandom_range(0, 15), 8'($urandom), $urandom_range(0, 3),
                         (i == 59) || ($urandom_range(0, 3) == 0));
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("random");
        check("model_empty", mbits.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
